// File: rtl/cell_tt_checker_pkg.sv
// cell_chk_pkg: shared FSM state type and constants
// for the exhaustive standard-cell truth-table checker.
package cell_chk_pkg;

  localparam int N_IN_DEF = 4;
  localparam int NVEC = 2**N_IN_DEF;

  // OAI22: ZN = ~((A1|A2)&(B1|B2)), A1 = vector MSB
  localparam logic [NVEC-1:0] OAI22_TT = 16'h111F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/cell_tt_checker_if.sv
// cell_chk_if: run control, cell stimulus/response
// and result bundle; slave = checker, master = user.
interface cell_chk_if
  import cell_chk_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);
  localparam int NV = 2**N_IN;

  logic            start;
  logic [NV-1:0]   exp_tt;
  logic [N_IN-1:0] vec_out;
  logic            dut_zn;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_fail_idx;
  logic            first_fail_vld;
  logic [NV-1:0]   obs_tt;

  modport slave (
    input  start, exp_tt, dut_zn,
    output vec_out, busy, done, pass,
    output err_cnt, first_fail_idx,
    output first_fail_vld, obs_tt
  );

  modport master (
    output start, exp_tt, dut_zn,
    input  vec_out, busy, done, pass,
    input  err_cnt, first_fail_idx,
    input  first_fail_vld, obs_tt
  );

endinterface

// File: rtl/cell_tt_checker_vecgen.sv
// cell_chk_vecgen: run FSM, vector index and settle
// counter; emits accept/sample strobes to the top.
module cell_chk_vecgen
  import cell_chk_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            accept,
  output logic            sample,
  output logic            last,
  output logic            busy,
  output logic [N_IN-1:0] idx
);
  localparam int WW = $clog2(SETTLE + 2);
  localparam logic [WW-1:0] WSET = WW'(SETTLE);
  // zero settle skips WAIT: one vector per cycle
  localparam state_t NXT =
    (SETTLE > 0) ? WAIT : SAMPLE;

  state_t        st;
  logic [WW-1:0] wcnt;

  assign accept = start &&
    (st == IDLE || st == DONE);
  assign sample = (st == SAMPLE);
  assign last   = &idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      idx  <= '0;
      wcnt <= '0;
      busy <= 1'b0;
    end else begin
      unique case (st)
        IDLE, DONE: begin
          if (start) begin
            idx  <= '0;
            wcnt <= WSET;
            busy <= 1'b1;
            st   <= NXT;
          end
        end
        WAIT: begin
          wcnt <= wcnt - WW'(1);
          if (wcnt == WW'(1)) st <= SAMPLE;
        end
        SAMPLE: begin
          if (last) begin
            busy <= 1'b0;
            st   <= DONE;
          end else begin
            idx  <= idx + N_IN'(1);
            wcnt <= WSET;
            st   <= NXT;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cell_tt_checker.sv
// cell_tt_checker: steps a cell through all input
// vectors, captures ZN and compares to a latched table.
module cell_tt_checker
  import cell_chk_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = 2
) (
  input logic       clk,
  input logic       rst_n,
  cell_chk_if.slave bus
);
  localparam int NV = 2**N_IN;

  logic            accept;
  logic            sample;
  logic            last;
  logic            mis;
  logic [N_IN-1:0] idx;
  logic [NV-1:0]   exp_q;
  logic [NV-1:0]   obs_q;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_nx;
  logic [N_IN-1:0] ffi_q;
  logic            ffv_q;
  logic            done_q;
  logic            pass_q;

  cell_chk_vecgen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vecgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.start),
    .accept (accept),
    .sample (sample),
    .last   (last),
    .busy   (bus.busy),
    .idx    (idx)
  );

  // an unknown ZN fails the equality test,
  // so it is counted as a mismatch
  always_comb begin
    mis = 1'b1;
    if (bus.dut_zn == exp_q[idx]) mis = 1'b0;
    err_nx = err_q + {{N_IN{1'b0}}, mis};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      obs_q  <= '0;
      err_q  <= '0;
      ffi_q  <= '0;
      ffv_q  <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (accept) begin
      exp_q  <= bus.exp_tt;
      obs_q  <= '0;
      err_q  <= '0;
      ffi_q  <= '0;
      ffv_q  <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (sample) begin
      obs_q[idx] <= bus.dut_zn;
      if (mis) begin
        err_q <= err_nx;
        if (!ffv_q) begin
          ffi_q <= idx;
          ffv_q <= 1'b1;
        end
      end
      if (last) begin
        done_q <= 1'b1;
        pass_q <= (err_nx == '0);
      end
    end
  end

  assign bus.vec_out        = idx;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_vld = ffv_q;
  assign bus.obs_tt         = obs_q;

endmodule

// File: doc/cell_tt_checker.md
Name: cell_tt_checker

Overview:
- Self-checking exhaustive truth-table checker for a 4-input standard cell (e.g. OAI22_X2); it is the response-capturing end of the stimulus interface.
- Steps through all 2^N_IN input vectors in order 0..2^N_IN-1, waits a settle time per vector, then samples the cell output.
- Compares each sample against a latched expected truth table and reports pass/fail, mismatch count, first failing vector and the captured table.
- Sits beside a cell instance in silicon/FPGA bring-up or in regression benches, replacing display-only benches.

Parameters:
- N_IN, 4: number of cell inputs; vectors = 2^N_IN.
- SETTLE, 2: wait cycles after a vector is applied before sampling (0 allowed).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  run request; accepted only in IDLE or DONE.
- exp_tt  in  2^N_IN  expected output; bit k = expected ZN for vector k. Latched on start acceptance.
- vec_out  out  N_IN  registered vector to the cell. MSB = first pin (A1), LSB = last pin (B2).
- dut_zn  in  1  cell output.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start or reset.
- pass  out  1  valid when done; 1 iff err_cnt == 0.
- err_cnt  out  N_IN+1  number of mismatching vectors.
- first_fail_idx  out  N_IN  lowest failing vector index; valid when first_fail_vld.
- first_fail_vld  out  1  at least one mismatch seen.
- obs_tt  out  2^N_IN  captured dut_zn per vector.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; all outputs 0. This includes vec_out, busy, done, pass, err_cnt, first_fail_idx, first_fail_vld and obs_tt. The latched table and counters are cleared.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE with start=1 at edge E:
  - latch exp_tt; idx=0; vec_out=0.
  - clear err_cnt, obs_tt, first_fail_*, done and pass.
  - busy=1; wcnt=SETTLE.
  - next state = WAIT if SETTLE>0, else SAMPLE.
- WAIT: decrement wcnt each cycle; enter SAMPLE when wcnt reaches 1.
- SAMPLE (one cycle), at its edge:
  - obs_tt[idx] = dut_zn.
  - If dut_zn != latched_exp[idx] (X/Z count as mismatch in simulation): err_cnt += 1. If first_fail_vld==0, set first_fail_idx=idx and first_fail_vld=1.
  - If idx == 2^N_IN-1: state=DONE, busy=0, done=1, pass=(final err_cnt==0).
  - Otherwise: idx+=1, vec_out=idx+1, wcnt=SETTLE, next state = WAIT if SETTLE>0, else SAMPLE.
- Timing:
  - Each vector is held exactly SETTLE+1 cycles; it is sampled on the last of those cycles.
  - done rises 2^N_IN*(SETTLE+1) edges after the start edge. With defaults that is 48.
  - vec_out holds the last vector in DONE.
- start while busy: ignored; no effect on the run.
- start with done=1: new run; done drops on the acceptance edge.
- exp_tt changes mid-run: no effect, because the table was latched at start.
- err_cnt cannot overflow; its width holds 2^N_IN.
- Reset mid-run: immediate abort to IDLE with all outputs cleared. No partial results are retained.

Decomposition:
- Shared package cell_chk_pkg holds:
  - state enum {IDLE, WAIT, SAMPLE, DONE};
  - localparam NVEC = 2**N_IN;
  - the OAI22 golden constant OAI22_TT = 16'h111F, for benches and defaults.
- One natural sub-module, cell_chk_vecgen: idx counter plus settle counter with apply/sample strobes.
- The top-level block owns compare, capture and status.

Test Plan:
- Golden OAI22 model (ZN = ~((A1|A2)&(B1|B2))), exp_tt=16'h111F, start pulse -> done at edge 48; pass=1, err_cnt=0, obs_tt=16'h111F, first_fail_vld=0; vec_out steps 0..15, each held 3 cycles.
- dut_zn stuck at 0, exp_tt=16'h111F -> done; pass=0, err_cnt=7, first_fail_idx=0, obs_tt=16'h0000.
- Golden model, exp_tt=16'h911F (bit 15 wrong) -> err_cnt=1, first_fail_idx=15, pass=0; no mismatch flagged before vector 15.
- start re-pulsed at vectors 3 and 9, plus exp_tt changed to 0 mid-run -> run unaffected: done at edge 48, pass=1. A subsequent start after done clears done/err_cnt and reruns identically.
- rst_n low while vec_out=6 -> same-cycle async clear: busy=0, done=0, obs_tt=0, vec_out=0. A following start completes a clean pass.
- SETTLE=0 build, golden model -> one vector per cycle; done 16 edges after start; pass=1.
